// File: rtl/bpu_resolve_if.sv
// Fetch/writeback-side bundle for bpu_resolve.
// Latency: none, wires only.
// Backpressure: pq_ready travels back toward fetch; writeback has no stall.
interface bpu_resolve_if #(
  parameter int XLEN = 32
) ();
  // fetch push side
  logic            pq_flush;
  logic            fch_valid_r;
  logic [XLEN-1:0] fch_pc_r;
  logic            bc_hit;
  logic [2:0]      bc_pred_type;
  logic [XLEN-1:0] bc_pred_target;
  logic            pq_ready;
  // writeback pop side
  logic            wrb_valid;
  logic [XLEN-1:0] wrb_pc;
  logic [2:0]      wrb_branch_type;
  logic            wrb_taken;
  logic [XLEN-1:0] wrb_target;
  // update stream, redirect, status
  logic            wrb_update_bpu;
  logic [XLEN-1:0] wrb_upd_pc;
  logic            wrb_mispred_typ;
  logic            wrb_mispred_tgt;
  logic [2:0]      wrb_upd_type;
  logic [XLEN-1:0] wrb_upd_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            pq_underflow;

  modport master (
    output pq_flush, fch_valid_r, fch_pc_r, bc_hit, bc_pred_type, bc_pred_target,
           wrb_valid, wrb_pc, wrb_branch_type, wrb_taken, wrb_target,
    input  pq_ready, wrb_update_bpu, wrb_upd_pc, wrb_mispred_typ, wrb_mispred_tgt,
           wrb_upd_type, wrb_upd_target, redirect, redirect_pc, pq_underflow
  );

  modport slave (
    input  pq_flush, fch_valid_r, fch_pc_r, bc_hit, bc_pred_type, bc_pred_target,
           wrb_valid, wrb_pc, wrb_branch_type, wrb_taken, wrb_target,
    output pq_ready, wrb_update_bpu, wrb_upd_pc, wrb_mispred_typ, wrb_mispred_tgt,
           wrb_upd_type, wrb_upd_target, redirect, redirect_pc, pq_underflow
  );
endinterface

// File: rtl/bpu_resolve.sv
// In-order prediction queue between fetch and writeback; resolves each retiring instruction against its fetch-time prediction.
// Latency: update stream and redirect are registered, valid the cycle after the pop.
// Backpressure: pq_ready drops when the queue is full (from registered count only); pushes while full are dropped.
module bpu_resolve #(
  parameter int PQ_SIZE = 2,
  parameter int XLEN    = 32
) (
  input logic          clk,
  input logic          reset_n,
  bpu_resolve_if.slave bus
);
  localparam logic [PQ_SIZE:0] FULL_CNT   = {1'b1, {PQ_SIZE{1'b0}}};
  localparam logic [XLEN-1:0]  INSN_BYTES = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            hit;
    logic [2:0]      typ;
    logic [XLEN-1:0] tgt;
  } pq_entry_t;

  pq_entry_t          mem_q [1<<PQ_SIZE];
  logic [PQ_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PQ_SIZE:0]   cnt_q, cnt_d;

  logic               upd_q, upd_d;
  logic               mis_typ_q, mis_typ_d;
  logic               mis_tgt_q, mis_tgt_d;
  logic               redirect_q, redirect_d;
  logic               unf_q, unf_d;
  logic [XLEN-1:0]    upd_pc_q, upd_pc_d;
  logic [2:0]         upd_type_q, upd_type_d;
  logic [XLEN-1:0]    upd_target_q, upd_target_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

  logic               push, pop;
  pq_entry_t          head;
  logic [2:0]         eff_type;
  logic [XLEN-1:0]    pred_next, act_next;

  assign bus.pq_ready        = (cnt_q != FULL_CNT);
  assign bus.wrb_update_bpu  = upd_q;
  assign bus.wrb_upd_pc      = upd_pc_q;
  assign bus.wrb_mispred_typ = mis_typ_q;
  assign bus.wrb_mispred_tgt = mis_tgt_q;
  assign bus.wrb_upd_type    = upd_type_q;
  assign bus.wrb_upd_target  = upd_target_q;
  assign bus.redirect        = redirect_q;
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.pq_underflow    = unf_q;

  // Queue control, resolution of the head entry, and next values of the update registers.
  always_comb begin
    push      = bus.fch_valid_r & bus.pq_ready & ~bus.pq_flush;
    // no bypass: a push into an empty queue is not visible to a same-cycle pop
    pop       = bus.wrb_valid & (cnt_q != '0) & ~bus.pq_flush;
    head      = mem_q[rd_ptr_q];
    eff_type  = head.hit ? head.typ : 3'd0;
    pred_next = (head.hit & (head.typ != 3'd0)) ? head.tgt : head.pc + INSN_BYTES;
    act_next  = bus.wrb_taken ? bus.wrb_target : bus.wrb_pc + INSN_BYTES;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.pq_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push & ~pop)      cnt_d = cnt_q + 1'b1;
      else if (pop & ~push) cnt_d = cnt_q - 1'b1;
    end

    // sticky: retire with nothing queued, or retire whose PC does not match the head
    unf_d = unf_q
          | (~bus.pq_flush & bus.wrb_valid & (cnt_q == '0))
          | (pop & (head.pc != bus.wrb_pc));

    upd_d         = 1'b0;
    mis_typ_d     = 1'b0;
    mis_tgt_d     = 1'b0;
    redirect_d    = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_type_d    = upd_type_q;
    upd_target_d  = upd_target_q;
    redirect_pc_d = redirect_pc_q;
    if (bus.pq_flush) begin
      upd_pc_d      = '0;
      upd_type_d    = '0;
      upd_target_d  = '0;
      redirect_pc_d = '0;
    end else if (pop) begin
      upd_d         = 1'b1;
      mis_typ_d     = (eff_type != bus.wrb_branch_type);
      mis_tgt_d     = (bus.wrb_branch_type != 3'd0) & bus.wrb_taken
                    & (~head.hit | (head.tgt != bus.wrb_target));
      redirect_d    = (pred_next != act_next);
      upd_pc_d      = bus.wrb_pc;
      upd_type_d    = bus.wrb_branch_type;
      upd_target_d  = bus.wrb_target;
      redirect_pc_d = act_next;
    end
  end

  // Prediction storage; contents are don't-care while the queue is empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: bus.fch_pc_r, hit: bus.bc_hit,
                                   typ: bus.bc_pred_type, tgt: bus.bc_pred_target};
  end

  // Pointers, count, sticky status and the registered update/redirect outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      unf_q         <= 1'b0;
      upd_q         <= 1'b0;
      mis_typ_q     <= 1'b0;
      mis_tgt_q     <= 1'b0;
      redirect_q    <= 1'b0;
      upd_pc_q      <= '0;
      upd_type_q    <= '0;
      upd_target_q  <= '0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      unf_q         <= unf_d;
      upd_q         <= upd_d;
      mis_typ_q     <= mis_typ_d;
      mis_tgt_q     <= mis_tgt_d;
      redirect_q    <= redirect_d;
      upd_pc_q      <= upd_pc_d;
      upd_type_q    <= upd_type_d;
      upd_target_q  <= upd_target_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
endmodule

// File: tb/tb_bpu_resolve.sv
// Bench for bpu_resolve: queue-based reference model, per-cycle compare, directed literal pins plus random traffic.
// Latency: model outputs follow the DUT's one-cycle registered update stream.
// Backpressure: model honours the 4-entry limit; pushes while full are dropped.
module tb_bpu_resolve;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  bpu_resolve_if #(.XLEN(32)) bus ();
  bpu_resolve #(.PQ_SIZE(2), .XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [2:0]  typ;
    logic [31:0] tgt;
  } pred_t;

  // reference model state: outstanding predictions in fetch order and expected outputs
  pred_t       mq[$];
  pred_t       e;
  bit          m_upd, m_mt, m_mg, m_red, m_unf;
  logic [31:0] m_pc = '0, m_tgt = '0, m_rpc = '0;
  logic [2:0]  m_typ = '0;
  logic [31:0] guess, truth;
  bit          p_pop, p_push;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the branch cache and fetch must see for each retiring instruction.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      {m_upd, m_mt, m_mg, m_red, m_unf} = '0;
      m_pc = '0; m_tgt = '0; m_rpc = '0; m_typ = '0;
    end else if (bus.pq_flush) begin
      mq.delete();
      {m_upd, m_mt, m_mg, m_red} = '0;
      m_pc = '0; m_tgt = '0; m_rpc = '0; m_typ = '0;
    end else begin
      p_pop  = bus.wrb_valid && mq.size() > 0;
      p_push = bus.fch_valid_r && mq.size() < 4;
      if (bus.wrb_valid && mq.size() == 0) m_unf = 1'b1;
      {m_upd, m_mt, m_mg, m_red} = '0;
      if (p_pop) begin
        e = mq.pop_front();
        if (e.pc != bus.wrb_pc) m_unf = 1'b1;
        guess  = (e.hit && e.typ != 3'd0) ? e.tgt : e.pc + 32'd4;
        truth  = bus.wrb_taken ? bus.wrb_target : bus.wrb_pc + 32'd4;
        m_upd  = 1'b1;
        m_mt   = ((e.hit ? e.typ : 3'd0) != bus.wrb_branch_type);
        m_mg   = (bus.wrb_branch_type != 3'd0) && bus.wrb_taken
                 && (!e.hit || e.tgt != bus.wrb_target);
        m_red  = (guess != truth);
        m_rpc  = truth;
        m_pc   = bus.wrb_pc;
        m_typ  = bus.wrb_branch_type;
        m_tgt  = bus.wrb_target;
      end
      if (p_push) mq.push_back('{bus.fch_pc_r, bus.bc_hit, bus.bc_pred_type, bus.bc_pred_target});
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      check("pq_ready",     bus.pq_ready,        32'(mq.size() != 4));
      check("update_bpu",   bus.wrb_update_bpu,  32'(m_upd));
      check("mispred_typ",  bus.wrb_mispred_typ, 32'(m_mt));
      check("mispred_tgt",  bus.wrb_mispred_tgt, 32'(m_mg));
      check("redirect",     bus.redirect,        32'(m_red));
      check("pq_underflow", bus.pq_underflow,    32'(m_unf));
      check("upd_pc",       bus.wrb_upd_pc,      m_pc);
      check("upd_type",     bus.wrb_upd_type,    32'(m_typ));
      check("upd_target",   bus.wrb_upd_target,  m_tgt);
      check("redirect_pc",  bus.redirect_pc,     m_rpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pq_flush = 0; bus.fch_valid_r = 0; bus.fch_pc_r = '0; bus.bc_hit = 0;
    bus.bc_pred_type = '0; bus.bc_pred_target = '0; bus.wrb_valid = 0; bus.wrb_pc = '0;
    bus.wrb_branch_type = '0; bus.wrb_taken = 0; bus.wrb_target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input bit hit, input logic [2:0] t, input logic [31:0] tg);
    bus.fch_valid_r = 1; bus.fch_pc_r = pc; bus.bc_hit = hit; bus.bc_pred_type = t; bus.bc_pred_target = tg;
    tick();
    bus.fch_valid_r = 0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [2:0] t, input bit tk, input logic [31:0] tg);
    bus.wrb_valid = 1; bus.wrb_pc = pc; bus.wrb_branch_type = t; bus.wrb_taken = tk; bus.wrb_target = tg;
    tick();
    bus.wrb_valid = 0;
  endtask

  logic [31:0] pc_ctr;

  initial begin
    idle();
    #1 reset_n = 0;
    #1;
    check("rst pq_ready",   bus.pq_ready, 32'd1);
    check("rst update",     bus.wrb_update_bpu, 32'd0);
    check("rst redirect",   bus.redirect, 32'd0);
    check("rst underflow",  bus.pq_underflow, 32'd0);
    check("rst redirect_pc", bus.redirect_pc, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    chk_en = 1;
    tick();

    // correct not-taken non-branch
    push(32'h100, 0, 3'd0, 32'h0);
    retire(32'h100, 3'd0, 0, 32'h0);
    check("t1 update",   bus.wrb_update_bpu, 32'd1);
    check("t1 mis_typ",  bus.wrb_mispred_typ, 32'd0);
    check("t1 mis_tgt",  bus.wrb_mispred_tgt, 32'd0);
    check("t1 redirect", bus.redirect, 32'd0);
    check("t1 rpc",      bus.redirect_pc, 32'h104);

    // hit with wrong target
    push(32'h200, 1, 3'd1, 32'h240);
    retire(32'h200, 3'd1, 1, 32'h280);
    check("t2 mis_tgt",  bus.wrb_mispred_tgt, 32'd1);
    check("t2 mis_typ",  bus.wrb_mispred_typ, 32'd0);
    check("t2 redirect", bus.redirect, 32'd1);
    check("t2 rpc",      bus.redirect_pc, 32'h280);

    // miss on a taken branch
    push(32'h300, 0, 3'd0, 32'h0);
    retire(32'h300, 3'd2, 1, 32'h400);
    check("t3 mis_typ", bus.wrb_mispred_typ, 32'd1);
    check("t3 mis_tgt", bus.wrb_mispred_tgt, 32'd1);
    check("t3 rpc",     bus.redirect_pc, 32'h400);

    // fall-through wraps at the top of the address space
    push(32'hFFFF_FFFC, 0, 3'd0, 32'h0);
    retire(32'hFFFF_FFFC, 3'd0, 0, 32'h0);
    check("wrap rpc",      bus.redirect_pc, 32'h0);
    check("wrap redirect", bus.redirect, 32'd0);

    // fill, overflow push dropped, in-order drain
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(16*i), 1, 3'd1, 32'h2000 + 32'(16*i));
    check("full pq_ready", bus.pq_ready, 32'd0);
    push(32'h9990, 1, 3'd1, 32'h5555);
    check("full still", bus.pq_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      retire(32'h1000 + 32'(16*i), 3'd1, 1, 32'h2000 + 32'(16*i));
      check("drain mis_tgt",  bus.wrb_mispred_tgt, 32'd0);
      check("drain redirect", bus.redirect, 32'd0);
    end
    check("drain ready", bus.pq_ready, 32'd1);

    // simultaneous push and pop leave the count unchanged
    for (int i = 0; i < 3; i++) push(32'h3000 + 32'(16*i), 0, 3'd0, 32'h0);
    bus.fch_valid_r = 1; bus.fch_pc_r = 32'h3030;
    retire(32'h3000, 3'd0, 0, 32'h0);
    check("pp ready", bus.pq_ready, 32'd1);
    push(32'h3040, 0, 3'd0, 32'h0);
    check("pp full", bus.pq_ready, 32'd0);
    for (int i = 1; i < 5; i++) retire(32'h3000 + 32'(16*i), 3'd0, 0, 32'h0);
    check("pp underflow", bus.pq_underflow, 32'd0);

    // random traffic
    pc_ctr = 32'hFFFF_FF00;
    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(99) < 2) bus.pq_flush = 1;
      if ($urandom_range(99) < 55) begin
        bus.fch_valid_r    = 1;
        bus.fch_pc_r       = pc_ctr;
        pc_ctr             = pc_ctr + 32'(4 * $urandom_range(1, 8));
        bus.bc_hit         = 1'($urandom_range(1));
        bus.bc_pred_type   = 3'($urandom_range(7));
        bus.bc_pred_target = 32'h8000 | (32'($urandom_range(7)) << 2);
      end
      if (mq.size() > 0 && $urandom_range(99) < 50) begin
        bus.wrb_valid       = 1;
        bus.wrb_pc          = mq[0].pc;
        bus.wrb_branch_type = ($urandom_range(1) == 1) ? mq[0].typ : 3'($urandom_range(7));
        bus.wrb_taken       = 1'($urandom_range(1));
        bus.wrb_target      = ($urandom_range(1) == 1) ? mq[0].tgt : 32'h8000 | (32'($urandom_range(7)) << 2);
      end
      tick();
    end
    idle();
    tick();

    // flush beats a same-cycle retire, then an empty retire sets the sticky flag
    bus.pq_flush = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) push(32'h4000 + 32'(16*i), 0, 3'd0, 32'h0);
    bus.pq_flush = 1;
    retire(32'h4000, 3'd2, 1, 32'h4800);
    idle();
    check("flush update",   bus.wrb_update_bpu, 32'd0);
    check("flush redirect", bus.redirect, 32'd0);
    check("flush ready",    bus.pq_ready, 32'd1);
    retire(32'h4010, 3'd0, 0, 32'h0);
    check("empty update",    bus.wrb_update_bpu, 32'd0);
    check("underflow set",   bus.pq_underflow, 32'd1);
    repeat (3) tick();
    check("underflow stays", bus.pq_underflow, 32'd1);

    // asynchronous reset while a redirect is pending
    push(32'h500, 1, 3'd1, 32'h540);
    retire(32'h500, 3'd1, 1, 32'h580);
    check("pre-reset redirect", bus.redirect, 32'd1);
    #2 reset_n = 0;
    #1;
    check("arst redirect",    bus.redirect, 32'd0);
    check("arst redirect_pc", bus.redirect_pc, 32'd0);
    check("arst update",      bus.wrb_update_bpu, 32'd0);
    check("arst underflow",   bus.pq_underflow, 32'd0);
    check("arst upd_pc",      bus.wrb_upd_pc, 32'd0);
    check("arst ready",       bus.pq_ready, 32'd1);
    @(posedge clk);
    #3 reset_n = 1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
